// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/call/return modes, a return-address
// stack with sticky overflow/underflow flags, and an instruction/data address mux.
module pc_unit #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               INC      = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             pc_w,
    input  logic [2:0]       pc_src,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] ALU_out,
    input  logic             IorD_select,
    input  logic             err_clr,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] IorD_out,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             ovf_err,
    output logic             unf_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] SEQ = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3, RET = 3'd4;

    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, tos;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    top_idx;
    logic             full_q, full_d, empty_q, empty_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             is_call, is_ret, push, pop;

    always_comb begin
        is_call = pc_w && pc_src == CALL;
        is_ret  = pc_w && pc_src == RET;
        push    = is_call && !full_q;
        pop     = is_ret && !empty_q;
        pc_inc  = pc_q + WIDTH'(INC);
        top_idx = AW'(cnt_q - CW'(1));
        tos     = stack_q[top_idx];
        pc_d    = !pc_w            ? pc_q :
                  pc_src == SEQ    ? pc_inc :
                  pc_src == BRANCH ? pc_q + offset :
                  pc_src == JUMP   ? target :
                  pc_src == CALL   ? target :
                  pc_src == RET    ? (empty_q ? pc_q : tos) : pc_q;
        cnt_d   = push ? cnt_q + CW'(1) : pop ? cnt_q - CW'(1) : cnt_q;
        full_d  = cnt_d == CW'(DEPTH);
        empty_d = cnt_d == '0;
        // a new error on the same edge as err_clr wins
        ovf_d   = (ovf_q && !err_clr) || (is_call && full_q);
        unf_d   = (unf_q && !err_clr) || (is_ret && empty_q);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // entries above count are don't-care, so the array needs no reset
    always_ff @(posedge CLK) begin
        if (push) stack_q[AW'(cnt_q)] <= pc_inc;
    end

    assign PC_out      = pc_q;
    assign IorD_out    = IorD_select ? ALU_out : pc_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit with DEPTH=4, WIDTH=16, INC=2, RESET_PC=0.
module tb_pc_unit;
    logic        CLK = 1'b0;
    logic        reset;
    logic        pc_w;
    logic [2:0]  pc_src;
    logic [15:0] offset, target, ALU_out;
    logic        IorD_select, err_clr;
    logic [15:0] PC_out, IorD_out;
    logic        stack_full, stack_empty, ovf_err, unf_err;
    int checks = 0;
    int errors = 0;

    pc_unit dut (
        .CLK(CLK), .reset(reset), .pc_w(pc_w), .pc_src(pc_src), .offset(offset),
        .target(target), .ALU_out(ALU_out), .IorD_select(IorD_select), .err_clr(err_clr),
        .PC_out(PC_out), .IorD_out(IorD_out), .stack_full(stack_full),
        .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic f, input logic e, input logic o, input logic u);
        chk({tag, ".full"}, {15'd0, stack_full}, {15'd0, f});
        chk({tag, ".empty"}, {15'd0, stack_empty}, {15'd0, e});
        chk({tag, ".ovf"}, {15'd0, ovf_err}, {15'd0, o});
        chk({tag, ".unf"}, {15'd0, unf_err}, {15'd0, u});
    endtask

    task automatic step(input logic w, input logic [2:0] src, input logic [15:0] off, input logic [15:0] tgt);
        pc_w = w; pc_src = src; offset = off; target = tgt;
        @(posedge CLK);
        #1;
        pc_w = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pc_w = 1'b0; pc_src = 3'd0; offset = '0; target = '0;
        ALU_out = '0; IorD_select = 1'b0; err_clr = 1'b0;
        #12;
        chk("reset.pc", PC_out, 16'h0000);
        flags("reset", 0, 1, 0, 0);
        @(negedge CLK); reset = 1'b1;
        step(1, 0, 0, 0); chk("seq1", PC_out, 16'h0002);
        step(1, 0, 0, 0); chk("seq2", PC_out, 16'h0004);
        step(1, 0, 0, 0); chk("seq3", PC_out, 16'h0006);
        chk("seq.empty", {15'd0, stack_empty}, 16'h0001);
        step(1, 2, 0, 16'hFFFE); chk("jump", PC_out, 16'hFFFE);
        step(1, 0, 0, 0); chk("seq.wrap", PC_out, 16'h0000);
        step(1, 1, 16'h0004, 0); chk("branch.fwd", PC_out, 16'h0004);
        step(1, 2, 0, 16'h0010);
        step(1, 1, 16'hFFF0, 0); chk("branch.back", PC_out, 16'h0000);
        step(1, 5, 16'h1234, 16'h5678); chk("hold", PC_out, 16'h0000);
        step(1, 2, 0, 16'h0020);
        step(1, 3, 0, 16'h0100); chk("call1", PC_out, 16'h0100);
        step(1, 3, 0, 16'h0200); chk("call2", PC_out, 16'h0200);
        step(1, 4, 0, 0); chk("ret1", PC_out, 16'h0102);
        step(1, 4, 0, 0); chk("ret2", PC_out, 16'h0022);
        flags("nest", 0, 1, 0, 0);
        step(1, 2, 0, 16'h0000);
        step(1, 3, 0, 16'h1000);
        step(1, 3, 0, 16'h2000);
        step(1, 3, 0, 16'h3000);
        step(1, 3, 0, 16'h4000); chk("call4", PC_out, 16'h4000);
        flags("call4", 1, 0, 0, 0);
        step(1, 3, 0, 16'h5000); chk("call5", PC_out, 16'h5000);
        flags("call5", 1, 0, 1, 0);
        step(1, 4, 0, 0); chk("ovret1", PC_out, 16'h3002);
        step(1, 4, 0, 0); chk("ovret2", PC_out, 16'h2002);
        step(1, 4, 0, 0); chk("ovret3", PC_out, 16'h1002);
        step(1, 4, 0, 0); chk("ovret4", PC_out, 16'h0002);
        flags("ovret4", 0, 1, 1, 0);
        step(1, 4, 0, 0); chk("unf.pc", PC_out, 16'h0002);
        flags("unf", 0, 1, 1, 1);
        step(0, 0, 0, 0); flags("sticky", 0, 1, 1, 1);
        err_clr = 1'b1;
        step(0, 0, 0, 0); flags("clr", 0, 1, 0, 0);
        err_clr = 1'b1;
        step(1, 4, 0, 0); flags("clr_vs_err", 0, 1, 0, 1);
        chk("clr_vs_err.pc", PC_out, 16'h0002);
        err_clr = 1'b1;
        step(0, 4, 0, 0); flags("clr2", 0, 1, 0, 0);
        step(1, 3, 0, 16'h0300);
        step(0, 3, 0, 16'h0400); chk("stall.pc", PC_out, 16'h0300);
        flags("stall", 0, 0, 0, 0);
        ALU_out = 16'hBEEF; IorD_select = 1'b0; #1;
        chk("iord0", IorD_out, 16'h0300);
        IorD_select = 1'b1; #1;
        chk("iord1", IorD_out, 16'hBEEF);
        IorD_select = 1'b0; #1;
        chk("iord0b", IorD_out, 16'h0300);
        step(1, 4, 0, 0); chk("stall.ret", PC_out, 16'h0004);
        chk("stall.ret.empty", {15'd0, stack_empty}, 16'h0001);
        step(1, 4, 0, 0);
        step(1, 3, 0, 16'h0500);
        step(1, 3, 0, 16'h0600); chk("pre_rst.pc", PC_out, 16'h0600);
        flags("pre_rst", 0, 0, 0, 1);
        pc_w = 1'b1; pc_src = 3'd3; target = 16'h0700;
        #1 reset = 1'b0;
        #2;
        chk("arst.pc", PC_out, 16'h0000);
        flags("arst", 0, 1, 0, 0);
        @(negedge CLK);
        chk("arst.hold.pc", PC_out, 16'h0000);
        reset = 1'b1;
        step(1, 0, 0, 0); chk("post_rst.seq", PC_out, 16'h0002);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16: PC, address and operand width in bits.
REQ-002 Parameter DEPTH, default 4: return-address stack entries; legal range 2..16.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Parameter INC, default 2: PC increment per sequential step.
REQ-005 CLK  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 pc_w  input  1  PC update enable; when 0, the PC and stack are held.
REQ-008 pc_src  input  3  next-PC mode: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5-7 HOLD.
REQ-009 offset  input  WIDTH  signed two's-complement branch offset.
REQ-010 target  input  WIDTH  absolute jump/call target.
REQ-011 ALU_out  input  WIDTH  data-address candidate for the IorD mux.
REQ-012 IorD_select  input  1  memory address source: 0 selects PC_out, 1 selects ALU_out.
REQ-013 err_clr  input  1  clears the sticky error flags.
REQ-014 PC_out  output  WIDTH  current PC register value.
REQ-015 IorD_out  output  WIDTH  memory address.
REQ-016 stack_full  output  1  high when the stack holds DEPTH entries.
REQ-017 stack_empty  output  1  high when the stack holds 0 entries.
REQ-018 ovf_err  output  1  sticky flag for CALL issued while full.
REQ-019 unf_err  output  1  sticky flag for RET issued while empty.

Function
REQ-020 IorD_out SHALL be combinational: equal to PC_out when IorD_select=0 and to ALU_out when IorD_select=1, with zero latency.
REQ-021 When pc_w=1, the PC SHALL load the mode result on the next edge. Latency from input to PC_out is one cycle.
- SEQ: PC+INC.
- BRANCH: PC+offset, with offset sign-extended.
- JUMP: target.
- CALL: target, and PC+INC is pushed.
- RET: the popped top-of-stack value.
- HOLD: PC unchanged.
REQ-022 All PC arithmetic SHALL wrap modulo 2^WIDTH; there is no carry-out and no error on wrap.
REQ-023 When pc_w=0, PC, stack contents, stack count and error flags SHALL be unchanged, regardless of pc_src.
REQ-024 The stack SHALL be LIFO, with a count ranging 0..DEPTH.
- stack_full is asserted when count==DEPTH.
- stack_empty is asserted when count==0.
- Both flags are registered outputs derived from count.
REQ-025 CALL while full SHALL still load target into the PC, discard the push, leave count at DEPTH, and set ovf_err.
REQ-026 RET while empty SHALL leave the PC unchanged, leave count at 0, and set unf_err.
REQ-027 A CALL immediately followed by a RET SHALL return exactly the pushed PC+INC, with no bubble cycle.
REQ-028 Error flags SHALL stay set until err_clr=1 at a clock edge.
- err_clr is independent of pc_w.
- If err_clr and a new error event occur on the same edge, the flag SHALL end set.
REQ-029 Stack entry contents not covered by count are don't-care and SHALL never be observable at any output.

Reset
REQ-030 Asserting reset=0 SHALL immediately, without waiting for a clock edge, force:
- PC_out=RESET_PC
- count=0, so stack_empty=1 and stack_full=0
- ovf_err=0 and unf_err=0
REQ-031 Reset asserted mid-operation SHALL abandon any pending update; the first edge after reset release performs a normal update from RESET_PC.
REQ-032 Reset deassertion SHALL be treated as synchronous to CLK by the surrounding system; no internal synchronizer is required.

Verification
REQ-033 Reset and sequential step: reset=0 pulse, then pc_w=1 with SEQ for 3 cycles -> PC_out is 0x0000, 0x0002, 0x0004, 0x0006 and stack_empty=1.
REQ-034 Branch and wrap-around:
- From PC=0xFFFE, SEQ -> PC=0x0000.
- From PC=0x0010, BRANCH with offset=0xFFF0 -> PC=0x0000.
REQ-035 Nested call/return: with DEPTH=4, issue CALL to 0x0100 from 0x0020, then CALL to 0x0200, then RET, RET -> PC_out is 0x0100, 0x0200, 0x0102, 0x0022; stack_empty=1 at the end.
REQ-036 Overflow and underflow:
- 5 CALLs with DEPTH=4 -> stack_full=1, ovf_err=1, and the 5th target is loaded.
- 5 RETs -> 4 valid returns, then PC held, unf_err=1.
- err_clr for one cycle -> both flags 0.
REQ-037 Stall and IorD mux:
- pc_w=0 with CALL asserted -> PC and count unchanged.
- IorD_select toggles 0/1 with ALU_out=0xBEEF -> IorD_out alternates PC_out and 0xBEEF in the same cycle.
REQ-038 Asynchronous reset mid-CALL: with count=2, assert reset=0 between clock edges -> PC_out=RESET_PC, stack_empty=1 and both error flags=0, all before the next edge.
